mod_exp_ctrl: RTL

MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

---
 rtl/mod_exp_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation sequencer: drives an external Montgomery multiplier
// through left-to-right square-and-multiply over every exponent bit.
// Handshake with the multiplier: mont_start is a level held high together with
// stable mont_x/mont_y until mont_done is seen; the product is taken on the
// first mont_done cycle, then mont_start drops for exactly one cycle before the
// next operation so the multiplier can return to idle.
module mod_exp_ctrl #(
    parameter int                N_BIT    = 7,
    parameter int                E_BIT    = 8,
    parameter logic [N_BIT-1:0]  R_MOD_N  = 7'd38,
    parameter logic [N_BIT-1:0]  R2_MOD_N = 7'd22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_BIT-1:0] base,
    input  logic [E_BIT-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic [N_BIT-1:0] result,
    output logic [N_BIT-1:0] mont_x,
    output logic [N_BIT-1:0] mont_y,
    output logic             mont_start,
    input  logic [N_BIT-1:0] mont_z,
    input  logic             mont_done
);

    localparam int CW = (E_BIT > 1) ? $clog2(E_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CONV = 3'd1,
        S_SQR  = 3'd2,
        S_MUL  = 3'd3,
        S_FROM = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    // Sub-phase of every multiplier operation state
    typedef enum logic {
        P_ISSUE   = 1'b0,
        P_RELEASE = 1'b1
    } phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [N_BIT-1:0]  reg_b_q, reg_b_d;
    logic [E_BIT-1:0]  reg_e_q, reg_e_d;
    logic [N_BIT-1:0]  acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_BIT-1:0]  result_q, result_d;
    logic [N_BIT-1:0]  mont_x_q, mont_x_d;
    logic [N_BIT-1:0]  mont_y_q, mont_y_d;
    logic              op_state;

    // Outputs decode straight from state so reset clears them immediately
    assign op_state   = (state_q == S_CONV) || (state_q == S_SQR) ||
                        (state_q == S_MUL)  || (state_q == S_FROM);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FIN);
    assign mont_start = op_state && (phase_q == P_ISSUE);
    assign result     = result_q;
    assign mont_x     = mont_x_q;
    assign mont_y     = mont_y_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= P_ISSUE;
            reg_b_q  <= '0;
            reg_e_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            mont_x_q <= '0;
            mont_y_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            reg_b_q  <= reg_b_d;
            reg_e_q  <= reg_e_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            mont_x_q <= mont_x_d;
            mont_y_q <= mont_y_d;
        end
    end

    // Next-state, capture and operand selection
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        reg_b_d  = reg_b_q;
        reg_e_d  = reg_e_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    reg_b_d = base;
                    reg_e_d = exp;
                    acc_d   = R_MOD_N;
                    cnt_d   = CW'(E_BIT - 1);
                    state_d = S_CONV;
                    phase_d = P_ISSUE;
                end
            end
            S_CONV, S_SQR, S_MUL, S_FROM: begin
                if (phase_q == P_ISSUE) begin
                    // mont_done outside ISSUE never reaches this branch
                    if (mont_done) begin
                        case (state_q)
                            S_CONV:  reg_b_d  = mont_z;
                            S_FROM:  result_d = mont_z;
                            default: acc_d    = mont_z;
                        endcase
                        phase_d = P_RELEASE;
                    end
                end else begin
                    phase_d = P_ISSUE;
                    case (state_q)
                        S_CONV: state_d = S_SQR;
                        S_FROM: state_d = S_FIN;
                        default: begin
                            if (state_q == S_SQR && reg_e_q[cnt_q]) begin
                                state_d = S_MUL;
                            end else if (cnt_q == '0) begin
                                state_d = S_FROM;
                            end else begin
                                cnt_d   = cnt_q - 1'b1;
                                state_d = S_SQR;
                            end
                        end
                    endcase
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                phase_d = P_ISSUE;
            end
        endcase

        // Operands follow the upcoming state; they only move outside ISSUE
        case (state_d)
            S_CONV: begin
                mont_x_d = reg_b_d;
                mont_y_d = R2_MOD_N;
            end
            S_SQR: begin
                mont_x_d = acc_d;
                mont_y_d = acc_d;
            end
            S_MUL: begin
                mont_x_d = acc_d;
                mont_y_d = reg_b_d;
            end
            S_FROM: begin
                mont_x_d = acc_d;
                mont_y_d = N_BIT'(1);
            end
            default: begin
                mont_x_d = '0;
                mont_y_d = '0;
            end
        endcase
    end

endmodule
